// File: rtl/maf_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : maf_dot_sequencer
// Purpose  : Sequences an N-term dot product through one external
//            multiply-accumulate datapath (C +/- A*B). Operand pairs come
//            from a valid/ready stream, one pair at a time. Each datapath
//            result becomes C for the next pair. The final accumulator goes
//            out on a valid/ready result port.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk            clock, rising edge
//   rst            synchronous reset, active low
//   start_i        job start (only honoured while idle)
//   len_i          term count N, sampled on start
//   c_init_i       initial accumulator, sampled on start
//   sub_i          0: C+A*B, 1: C-A*B, sampled on start
//   busy_o         high whenever a job is active
//   op_valid_i     operand pair valid
//   op_ready_o     operand pair ready
//   a_i, b_i       operand pair
//   maf_a_o/b_o/c_o  registered datapath operands
//   maf_sub_o      registered datapath add/sub control
//   maf_result_i   datapath result, valid maf_latency cycles after issue
//   res_valid_o    result valid
//   res_ready_i    result consumer ready
//   result_o       accumulated result
//   count_o        terms completed in the current job
// Build option
//   MAF_DOT_ZERO_SKIP_EN : when defined, an accepted pair with a zero operand
//                          (exception tag 00) skips the datapath and only
//                          advances the term counters.
// ============================================================================
module maf_dot_sequencer #(
  parameter int size_mantissa        = 24,
  parameter int size_exponent        = 8,
  parameter int size_exception_field = 2,
  parameter int size_len             = 8,
  parameter int maf_latency          = 1,
  parameter int size                 = size_exponent + size_mantissa + size_exception_field
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [size_len-1:0] len_i,
  input  logic [size-1:0]     c_init_i,
  input  logic                sub_i,
  output logic                busy_o,
  input  logic                op_valid_i,
  output logic                op_ready_o,
  input  logic [size-1:0]     a_i,
  input  logic [size-1:0]     b_i,
  output logic [size-1:0]     maf_a_o,
  output logic [size-1:0]     maf_b_o,
  output logic [size-1:0]     maf_c_o,
  output logic                maf_sub_o,
  input  logic [size-1:0]     maf_result_i,
  output logic                res_valid_o,
  input  logic                res_ready_i,
  output logic [size-1:0]     result_o,
  output logic [size_len-1:0] count_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // The latency counter reads 0 in the cycle the datapath result is valid.
  localparam logic [3:0]          c_lat_init = 4'(maf_latency - 1);
  localparam logic [size_len-1:0] c_len_one  = size_len'(1);

  state_t              state_q,     state_d;
  logic [size-1:0]     acc_q,       acc_d;
  logic [size_len-1:0] remaining_q, remaining_d;
  logic [3:0]          lat_q,       lat_d;
  logic [size_len-1:0] count_q,     count_d;
  logic [size-1:0]     maf_a_q,     maf_a_d;
  logic [size-1:0]     maf_b_q,     maf_b_d;
  logic [size-1:0]     maf_c_q,     maf_c_d;
  logic                maf_sub_q,   maf_sub_d;
  logic                op_ready_q,  op_ready_d;
  logic                res_valid_q, res_valid_d;
  logic [size-1:0]     result_q,    result_d;
  logic                busy_q,      busy_d;

  logic                w_op_hs;
  logic                w_skip;

  assign w_op_hs = op_valid_i && op_ready_q;

`ifdef MAF_DOT_ZERO_SKIP_EN
  // A zero operand makes the product zero, so the accumulator is unchanged.
  assign w_skip = (a_i[size-1 -: size_exception_field] == '0) ||
                  (b_i[size-1 -: size_exception_field] == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    remaining_d = remaining_q;
    lat_d       = lat_q;
    count_d     = count_q;
    maf_a_d     = maf_a_q;
    maf_b_d     = maf_b_q;
    maf_c_d     = maf_c_q;
    maf_sub_d   = maf_sub_q;
    result_d    = result_q;
    res_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          remaining_d = len_i;
          acc_d       = c_init_i;
          maf_sub_d   = sub_i;
          count_d     = '0;
          state_d     = (len_i == '0) ? ST_DONE : ST_FETCH;
        end
      end

      ST_FETCH: begin
        if (w_op_hs) begin
          if (w_skip) begin
            remaining_d = remaining_q - c_len_one;
            count_d     = count_q + c_len_one;
            if (remaining_q == c_len_one) begin
              state_d = ST_DONE;
            end
          end else begin
            maf_a_d = a_i;
            maf_b_d = b_i;
            maf_c_d = acc_q;
            lat_d   = c_lat_init;
            state_d = ST_WAIT;
          end
        end
      end

      ST_WAIT: begin
        if (lat_q == '0) begin
          acc_d       = maf_result_i;
          remaining_d = remaining_q - c_len_one;
          count_d     = count_q + c_len_one;
          state_d     = (remaining_q == c_len_one) ? ST_DONE : ST_FETCH;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end

      ST_DONE: begin
        // The result register fills on the first DONE cycle. It is then
        // presented, held, until the consumer takes it.
        result_d    = acc_q;
        res_valid_d = 1'b1;
        if (res_valid_q && res_ready_i) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    op_ready_d = (state_d == ST_FETCH);
    busy_d     = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      remaining_q <= '0;
      lat_q       <= '0;
      count_q     <= '0;
      maf_a_q     <= '0;
      maf_b_q     <= '0;
      maf_c_q     <= '0;
      maf_sub_q   <= 1'b0;
      op_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      remaining_q <= remaining_d;
      lat_q       <= lat_d;
      count_q     <= count_d;
      maf_a_q     <= maf_a_d;
      maf_b_q     <= maf_b_d;
      maf_c_q     <= maf_c_d;
      maf_sub_q   <= maf_sub_d;
      op_ready_q  <= op_ready_d;
      res_valid_q <= res_valid_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
    end
  end

  assign busy_o      = busy_q;
  assign op_ready_o  = op_ready_q;
  assign maf_a_o     = maf_a_q;
  assign maf_b_o     = maf_b_q;
  assign maf_c_o     = maf_c_q;
  assign maf_sub_o   = maf_sub_q;
  assign res_valid_o = res_valid_q;
  assign result_o    = result_q;
  assign count_o     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_maf_dot_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_maf_dot_sequencer
// Purpose  : Self-checking bench for maf_dot_sequencer. A floating-point
//            datapath stub with a fixed pipeline latency feeds the sequencer.
//            A transaction-level model predicts every output on every cycle.
//            Directed jobs pin the model with hand-computed results.
// Revision : 1.0  initial release
// ============================================================================
module tb_maf_dot_sequencer;

  localparam int LAT = 4;
  localparam int SZ  = 34;
  localparam int LW  = 8;

`ifdef MAF_DOT_ZERO_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  localparam logic [SZ-1:0] F_ONE   = 34'h13F800000;
  localparam logic [SZ-1:0] F_TWO   = 34'h140000000;
  localparam logic [SZ-1:0] F_THREE = 34'h140400000;
  localparam logic [SZ-1:0] F_TEN   = 34'h141200000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic [SZ-1:0] c_init_i = '0;
  logic          sub_i = 1'b0;
  logic          busy_o;
  logic          op_valid_i = 1'b0;
  logic          op_ready_o;
  logic [SZ-1:0] a_i = '0;
  logic [SZ-1:0] b_i = '0;
  logic [SZ-1:0] maf_a_o, maf_b_o, maf_c_o;
  logic          maf_sub_o;
  logic [SZ-1:0] maf_result_i;
  logic          res_valid_o;
  logic          res_ready_i = 1'b0;
  logic [SZ-1:0] result_o;
  logic [LW-1:0] count_o;

  always #5 clk = ~clk;

  maf_dot_sequencer #(
    .maf_latency(LAT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .len_i        (len_i),
    .c_init_i     (c_init_i),
    .sub_i        (sub_i),
    .busy_o       (busy_o),
    .op_valid_i   (op_valid_i),
    .op_ready_o   (op_ready_o),
    .a_i          (a_i),
    .b_i          (b_i),
    .maf_a_o      (maf_a_o),
    .maf_b_o      (maf_b_o),
    .maf_c_o      (maf_c_o),
    .maf_sub_o    (maf_sub_o),
    .maf_result_i (maf_result_i),
    .res_valid_o  (res_valid_o),
    .res_ready_i  (res_ready_i),
    .result_o     (result_o),
    .count_o      (count_o)
  );

  // ---------------- float helpers (tag 01 normal, tag 00 zero) -------------
  function automatic real to_real(input logic [SZ-1:0] x);
    logic [63:0] d;
    logic [10:0] e;
    if (x[33:32] != 2'b01) return 0.0;
    e = 11'(x[30:23]) - 11'd127 + 11'd1023;
    d = {x[31], e, x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [SZ-1:0] from_real(input real r);
    logic [63:0] d;
    logic [10:0] e;
    if (r == 0.0) return '0;
    d = $realtobits(r);
    e = d[62:52] - 11'd1023 + 11'd127;
    return {2'b01, d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [SZ-1:0] maf(input logic [SZ-1:0] a, input logic [SZ-1:0] b,
                                        input logic [SZ-1:0] c, input logic s);
    real p;
    p = to_real(a) * to_real(b);
    return from_real(s ? (to_real(c) - p) : (to_real(c) + p));
  endfunction

  function automatic logic [SZ-1:0] rnd_num();
    if ($urandom_range(9) == 0) return '0;
    return {2'b01, 1'($urandom_range(1)), 8'(120 + $urandom_range(14)), 23'($urandom)};
  endfunction

  // ---------------- datapath stub: result valid LAT cycles after issue -----
  logic [SZ-1:0] pipe [0:LAT-2];
  always @(posedge clk) begin
    pipe[0] <= maf(maf_a_o, maf_b_o, maf_c_o, maf_sub_o);
    for (int k = 1; k < LAT - 1; k++) pipe[k] <= pipe[k-1];
  end
  assign maf_result_i = pipe[LAT-2];

  // ---------------- bookkeeping -------------------------------------------
  int cyc = 0;
  int n_checks = 0;
  int n_err = 0;
  logic [SZ-1:0] pa [256];
  logic [SZ-1:0] pb [256];

  task automatic chk(input string nm, input logic [SZ-1:0] act, input logic [SZ-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- transaction-level reference model ----------------------
  bit            m_active = 0, m_ready = 0, m_valid = 0;
  int            m_due = -1, m_cap = -1;
  logic [LW-1:0] m_n = '0, m_count = '0;
  logic [SZ-1:0] m_acc = '0, e_a = '0, e_b = '0, e_c = '0, e_res = '0;
  logic          e_sub = 1'b0;

  logic          s_rst, s_start, s_sub, s_valid, s_rr;
  logic [LW-1:0] s_len;
  logic [SZ-1:0] s_c, s_a, s_b;

  task automatic model_step();
    bit skip;
    if (!s_rst) begin
      m_active = 0; m_ready = 0; m_valid = 0; m_due = -1; m_cap = -1;
      m_n = '0; m_count = '0; m_acc = '0;
      e_a = '0; e_b = '0; e_c = '0; e_res = '0; e_sub = 1'b0;
    end else if (!m_active) begin
      if (s_start) begin
        m_active = 1; m_n = s_len; m_acc = s_c; e_sub = s_sub; m_count = '0;
        if (s_len == '0) m_due = cyc + 1;
        else m_ready = 1;
      end
    end else begin
      if (m_valid && s_rr) begin
        m_active = 0; m_valid = 0;
      end else if (m_ready && s_valid) begin
        skip = SKIP && (s_a[33:32] == 2'b00 || s_b[33:32] == 2'b00);
        if (skip) begin
          m_count++;
          if (m_count == m_n) begin m_ready = 0; m_due = cyc + 1; end
        end else begin
          e_a = s_a; e_b = s_b; e_c = m_acc; m_ready = 0; m_cap = cyc + LAT;
        end
      end
      if (m_cap == cyc) begin
        m_acc = maf(e_a, e_b, e_c, e_sub);
        m_count++; m_cap = -1;
        if (m_count == m_n) m_due = cyc + 1;
        else m_ready = 1;
      end
      if (m_due == cyc) begin
        m_valid = 1; e_res = m_acc; m_due = -1;
      end
    end
  endtask

  // Inputs are stable across the rising edge (driven on the falling edge);
  // outputs are compared 1 time unit after the edge.
  always begin
    @(posedge clk);
    s_rst = rst; s_start = start_i; s_len = len_i; s_c = c_init_i; s_sub = sub_i;
    s_valid = op_valid_i; s_a = a_i; s_b = b_i; s_rr = res_ready_i;
    #1;
    cyc++;
    model_step();
    chk("busy_o",      busy_o,      m_active);
    chk("op_ready_o",  op_ready_o,  m_ready);
    chk("res_valid_o", res_valid_o, m_valid);
    chk("result_o",    result_o,    e_res);
    chk("count_o",     count_o,     m_count);
    chk("maf_a_o",     maf_a_o,     e_a);
    chk("maf_b_o",     maf_b_o,     e_b);
    chk("maf_c_o",     maf_c_o,     e_c);
    chk("maf_sub_o",   maf_sub_o,   e_sub);
  end

  // ---------------- job driver ---------------------------------------------
  task automatic run_job(input int n, input logic [SZ-1:0] c, input bit sub,
                         input int pct, input int lo, input int abort_at,
                         output logic [SZ-1:0] res, output int cnt,
                         output int lat, output bit saw_ready);
    int idx, hold, guard, t0;
    bit rdy_prev, rv_prev, fin;
    idx = 0; hold = 0; guard = 0; rdy_prev = 0; rv_prev = 0; fin = 0;
    res = '0; cnt = 0; lat = -1; saw_ready = 0;
    @(negedge clk);
    start_i = 1'b1; len_i = LW'(n); c_init_i = c; sub_i = sub;
    op_valid_i = 1'b0; res_ready_i = 1'b0;
    t0 = cyc;
    while (!fin && guard < 4000) begin
      @(negedge clk);
      guard++;
      if (op_valid_i && rdy_prev) idx++;
      if (rv_prev && res_ready_i) begin
        fin = 1;
      end else if (abort_at >= 0 && idx == abort_at) begin
        rst = 1'b0; start_i = 1'b0; op_valid_i = 1'b0; res_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        chk("abort_busy",     busy_o,      1'b0);
        chk("abort_op_ready", op_ready_o,  1'b0);
        chk("abort_valid",    res_valid_o, 1'b0);
        chk("abort_maf_a",    maf_a_o,     '0);
        chk("abort_count",    count_o,     '0);
        fin = 1;
      end else begin
        rdy_prev = op_ready_o;
        rv_prev  = res_valid_o;
        if (op_ready_o) saw_ready = 1;
        if (res_valid_o && lat < 0) begin
          lat = cyc - (t0 + 1);
          res = result_o;
          cnt = int'(count_o);
        end
        if (res_valid_o) hold++;
        // Stray start requests while busy must be ignored.
        start_i  = ($urandom_range(7) == 0);
        len_i    = LW'($urandom);
        c_init_i = rnd_num();
        sub_i    = 1'($urandom_range(1));
        op_valid_i = (idx < n) && (pct >= 100 || $urandom_range(99) < pct);
        a_i = (idx < n) ? pa[idx] : rnd_num();
        b_i = (idx < n) ? pb[idx] : rnd_num();
        res_ready_i = res_valid_o ? (hold > lo) : ($urandom_range(1) == 1);
      end
    end
    start_i = 1'b0; op_valid_i = 1'b0; res_ready_i = 1'b0;
    if (!fin) begin
      n_checks++; n_err++;
      $display("FAIL job_timeout: got no completion expected completion within 4000 cycles");
    end
  endtask

  // ---------------- stimulus ------------------------------------------------
  initial begin
    logic [SZ-1:0] r;
    int cnt, lat, n, exp_lat;
    bit sr;

    repeat (2) @(negedge clk);
    chk("rst_busy",     busy_o,      1'b0);
    chk("rst_op_ready", op_ready_o,  1'b0);
    chk("rst_valid",    res_valid_o, 1'b0);
    chk("rst_result",   result_o,    '0);
    chk("rst_count",    count_o,     '0);
    chk("rst_maf_c",    maf_c_o,     '0);
    rst = 1'b1;

    // 1 + 1*2 + 2*2 + 1*3 = 10.0
    pa[0] = F_ONE; pb[0] = F_TWO;
    pa[1] = F_TWO; pb[1] = F_TWO;
    pa[2] = F_ONE; pb[2] = F_THREE;
    run_job(3, F_ONE, 1'b0, 100, 0, -1, r, cnt, lat, sr);
    chk("basic_result", r, 34'h141200000);
    chk("basic_count",  cnt, 3);
    chk("basic_latency", lat, 1 + 3 * (1 + LAT));

    // N = 0 returns c_init directly
    run_job(0, F_THREE, 1'b0, 100, 0, -1, r, cnt, lat, sr);
    chk("n0_result",   r, 34'h140400000);
    chk("n0_latency",  lat, 1);
    chk("n0_no_ready", sr, 1'b0);
    chk("n0_count",    cnt, 0);

    // 10 - 2*3 = 4.0
    pa[0] = F_TWO; pb[0] = F_THREE;
    run_job(1, F_TEN, 1'b1, 100, 0, -1, r, cnt, lat, sr);
    chk("sub_result",  r, 34'h140800000);
    chk("sub_latency", lat, 1 + (1 + LAT));

    // 1 + 1*2 + 0*3 + 2*2 = 7.0, with a zero operand in the middle
    pa[0] = F_ONE; pb[0] = F_TWO;
    pa[1] = '0;    pb[1] = F_THREE;
    pa[2] = F_TWO; pb[2] = F_TWO;
    exp_lat = SKIP ? (1 + 2 * (1 + LAT) + 1) : (1 + 3 * (1 + LAT));
    run_job(3, F_ONE, 1'b0, 100, 0, -1, r, cnt, lat, sr);
    chk("zero_result",  r, 34'h140E00000);
    chk("zero_count",   cnt, 3);
    chk("zero_latency", lat, exp_lat);

    // Reset during the datapath wait of term 2, then a clean job
    pa[0] = F_ONE; pb[0] = F_TWO;
    pa[1] = F_TWO; pb[1] = F_TWO;
    pa[2] = F_ONE; pb[2] = F_THREE;
    run_job(3, F_ONE, 1'b0, 100, 0, 2, r, cnt, lat, sr);
    run_job(3, F_ONE, 1'b0, 100, 0, -1, r, cnt, lat, sr);
    chk("post_reset_result", r, 34'h141200000);

    // Random jobs with operand and result backpressure
    for (int j = 0; j < 20; j++) begin
      n = $urandom_range(1, 8);
      for (int k = 0; k < n; k++) begin
        pa[k] = rnd_num();
        pb[k] = rnd_num();
      end
      run_job(n, rnd_num(), 1'($urandom_range(1)), 50, 5, -1, r, cnt, lat, sr);
      chk("rand_count", cnt, n);
    end

    // Maximum term count: 1 + 255*1 = 256.0, no counter wrap
    for (int k = 0; k < 255; k++) begin
      pa[k] = F_ONE;
      pb[k] = F_ONE;
    end
    run_job(255, F_ONE, 1'b0, 100, 0, -1, r, cnt, lat, sr);
    chk("max_result",  r, 34'h143800000);
    chk("max_count",   cnt, 255);
    chk("max_latency", lat, 1 + 255 * (1 + LAT));

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
